// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the bus master interface unit.
//   WORD_DATA / BUS_SLAVE_ADDR : default data / word-address widths
//   READ / WRITE               : encodings of the rw signals
//   state_e                    : master FSM state encoding
//   wd_width()                 : watchdog counter width for a given TIMEOUT
package bus_master_if_pkg;

  localparam int WORD_DATA      = 32;
  localparam int BUS_SLAVE_ADDR = 30;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    WAIT   = 2'd3
  } state_e;

  // One extra bit over clog2 so the count can reach TIMEOUT-1 and saturate
  // above it without wrapping; TIMEOUT=0 still yields a legal 1-bit counter.
  function automatic int wd_width(input int unsigned timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/bus_master_if_if.sv
// Core-side and bus-side signal bundle of one bus master.
//   master : view of the bus_master_if unit (drives cpu_busy/done/err/rd_data
//            and bus_req/addr/as/rw/wr_data)
//   slave  : view of the environment (core + bus arbiter/slave)
interface bus_master_if_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W = BUS_SLAVE_ADDR,
  parameter int DATA_W = WORD_DATA
) ();

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rw;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_busy;
  logic              cpu_done;
  logic              cpu_err;
  logic [DATA_W-1:0] cpu_rd_data;

  logic              bus_req;
  logic              bus_grnt;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic              bus_rdy;
  logic [DATA_W-1:0] bus_rd_data;

  modport master (
    input  cpu_req, cpu_addr, cpu_rw, cpu_wr_data,
    output cpu_busy, cpu_done, cpu_err, cpu_rd_data,
    output bus_req, bus_addr, bus_as, bus_rw, bus_wr_data,
    input  bus_grnt, bus_rdy, bus_rd_data
  );

  modport slave (
    output cpu_req, cpu_addr, cpu_rw, cpu_wr_data,
    input  cpu_busy, cpu_done, cpu_err, cpu_rd_data,
    input  bus_req, bus_addr, bus_as, bus_rw, bus_wr_data,
    output bus_grnt, bus_rdy, bus_rd_data
  );

endinterface

// File: rtl/bus_master_if_watchdog_cnt.sv
// bus_watchdog_cnt: saturating cycle counter that flags an access timeout.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force count to 0 (priority over enable)
//   enable   : count this cycle
//   expire   : count has reached TIMEOUT-1 (never asserted when TIMEOUT=0)
module bus_watchdog_cnt
  import bus_master_if_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int          W      = wd_width(TIMEOUT);
  localparam int unsigned LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [W-1:0] LAST  = LAST_I[W-1:0];
  localparam logic [W-1:0] MAX   = '1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                        cnt_d = '0;
    else if (enable && cnt_q != MAX)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/bus_master_if.sv
// bus_master_if: turns a single-beat core load/store into a bus access
// (req/grnt arbitration, one-cycle address strobe, wait for slave ready),
// with a watchdog that aborts accesses whose slave never answers.
//   clk  : clock
//   rest : synchronous active-high reset
//   bif  : master modport carrying cpu_* (core side) and bus_* (bus side)
// Every output is a flop; next values are computed in one always_comb.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W  = BUS_SLAVE_ADDR,
  parameter int DATA_W  = WORD_DATA,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rest,
  bus_master_if_if.master bif
);

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_as_q, bus_as_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_rw_q, bus_rw_d;
  logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
  logic              cpu_busy_q, cpu_busy_d;
  logic              cpu_done_q, cpu_done_d;
  logic              cpu_err_q, cpu_err_d;
  logic [DATA_W-1:0] cpu_rd_data_q, cpu_rd_data_d;

  logic wd_clr, wd_en, wd_expire;

  bus_watchdog_cnt #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst    (rest),
    .clear  (wd_clr),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = 1'b0;
    bus_addr_d    = bus_addr_q;
    bus_rw_d      = bus_rw_q;
    bus_wr_data_d = bus_wr_data_q;
    cpu_busy_d    = cpu_busy_q;
    cpu_done_d    = 1'b0;
    cpu_err_d     = 1'b0;
    cpu_rd_data_d = cpu_rd_data_q;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bif.cpu_req) begin
          bus_addr_d    = bif.cpu_addr;
          bus_rw_d      = bif.cpu_rw;
          bus_wr_data_d = bif.cpu_wr_data;
          bus_req_d     = 1'b1;
          cpu_busy_d    = 1'b1;
          state_d       = REQ;
        end
      end
      REQ: begin
        // Arbitration wait is unbounded; the watchdog starts at the strobe.
        if (bif.bus_grnt) begin
          bus_as_d = 1'b1;
          wd_clr   = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS, WAIT: begin
        wd_en = 1'b1;
        // Ready wins over a coincident watchdog expiry.
        if (bif.bus_rdy) begin
          bus_req_d  = 1'b0;
          cpu_busy_d = 1'b0;
          cpu_done_d = 1'b1;
          if (bus_rw_q != WRITE) cpu_rd_data_d = bif.bus_rd_data;
          state_d    = IDLE;
        end else if (wd_expire) begin
          bus_req_d  = 1'b0;
          cpu_busy_d = 1'b0;
          cpu_err_d  = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b0;
      bus_as_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_rw_q      <= READ;
      bus_wr_data_q <= '0;
      cpu_busy_q    <= 1'b0;
      cpu_done_q    <= 1'b0;
      cpu_err_q     <= 1'b0;
      cpu_rd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_addr_q    <= bus_addr_d;
      bus_rw_q      <= bus_rw_d;
      bus_wr_data_q <= bus_wr_data_d;
      cpu_busy_q    <= cpu_busy_d;
      cpu_done_q    <= cpu_done_d;
      cpu_err_q     <= cpu_err_d;
      cpu_rd_data_q <= cpu_rd_data_d;
    end
  end

  assign bif.bus_req     = bus_req_q;
  assign bif.bus_as      = bus_as_q;
  assign bif.bus_addr    = bus_addr_q;
  assign bif.bus_rw      = bus_rw_q;
  assign bif.bus_wr_data = bus_wr_data_q;
  assign bif.cpu_busy    = cpu_busy_q;
  assign bif.cpu_done    = cpu_done_q;
  assign bif.cpu_err     = cpu_err_q;
  assign bif.cpu_rd_data = cpu_rd_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Scenario tasks drive the core/bus side at the falling edge and check the
// registered outputs there; a falling-edge monitor pops the scoreboard on
// every cpu_done/cpu_err pulse and checks the outcome and read data.
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk  = 1'b0;
  logic rest = 1'b1;

  bus_master_if_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rest (rest),
    .bif  (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          err;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            passes = 0;
  logic [DW-1:0] exp_rd = '0;

  localparam logic [AW+DW+DW+5:0] RST_VALS = {1'b0, 1'b0, {AW{1'b0}}, 1'b1, {DW{1'b0}},
                                              1'b0, 1'b0, 1'b0, {DW{1'b0}}};

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard / invariant monitor
  always @(negedge clk) begin
    checks++;
    if ((bif.cpu_done & bif.cpu_err) !== 1'b0)
      $display("FAIL done_err_exclusive: done=%b err=%b", bif.cpu_done, bif.cpu_err);
    else passes++;
    checks++;
    if (bif.bus_as === 1'b1 && bif.bus_req !== 1'b1)
      $display("FAIL as_without_req: as=%b req=%b", bif.bus_as, bif.bus_req);
    else passes++;
    if (bif.cpu_done === 1'b1 || bif.cpu_err === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse: done=%b err=%b, none expected", bif.cpu_done, bif.cpu_err);
      end else begin
        mon_e = sb.pop_front();
        if ({bif.cpu_err, bif.cpu_rd_data} !== {mon_e.err, mon_e.rd})
          $display("FAIL completion: err=%b rd=%h, expected err=%b rd=%h",
                   bif.cpu_err, bif.cpu_rd_data, mon_e.err, mon_e.rd);
        else passes++;
      end
    end
  end

  task automatic test_reset();
    rest = 1'b1;
    bif.cpu_req = 1'b0; bif.cpu_addr = '0; bif.cpu_rw = 1'b1; bif.cpu_wr_data = '0;
    bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b0; bif.bus_rd_data = '0;
    repeat (3) tick();
    checks++;
    if ({bif.bus_req, bif.bus_as, bif.bus_addr, bif.bus_rw, bif.bus_wr_data,
         bif.cpu_busy, bif.cpu_done, bif.cpu_err, bif.cpu_rd_data} !== RST_VALS)
      $display("FAIL reset_values: got %h want %h",
               {bif.bus_req, bif.bus_as, bif.bus_addr, bif.bus_rw, bif.bus_wr_data,
                bif.cpu_busy, bif.cpu_done, bif.cpu_err, bif.cpu_rd_data}, RST_VALS);
    else passes++;
    rest = 1'b0;
    tick();
  endtask

  task automatic test_read_zero_wait(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bif.cpu_req = 1'b1; bif.cpu_addr = a; bif.cpu_rw = 1'b1; bif.cpu_wr_data = '0;
    bif.bus_grnt = 1'b1; bif.bus_rdy = 1'b1; bif.bus_rd_data = d;
    exp_rd = d;
    sb.push_back('{err: 1'b0, rd: d});
    tick();  // N+1
    checks++;
    if ({bif.bus_req, bif.bus_as, bif.cpu_busy, bif.bus_rw, bif.bus_addr} !== {4'b1011, a})
      $display("FAIL rd0_req: req/as/busy/rw=%b addr=%h, want 1011 addr=%h",
               {bif.bus_req, bif.bus_as, bif.cpu_busy, bif.bus_rw}, bif.bus_addr, a);
    else passes++;
    bif.cpu_req = 1'b0;
    tick();  // N+2
    checks++;
    if ({bif.bus_req, bif.bus_as, bif.cpu_done} !== 3'b110)
      $display("FAIL rd0_strobe: req/as/done=%b want 110", {bif.bus_req, bif.bus_as, bif.cpu_done});
    else passes++;
    tick();  // N+3
    checks++;
    if ({bif.bus_req, bif.bus_as, bif.cpu_busy, bif.cpu_done} !== 4'b0001)
      $display("FAIL rd0_done: req/as/busy/done=%b want 0001",
               {bif.bus_req, bif.bus_as, bif.cpu_busy, bif.cpu_done});
    else passes++;
    bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b0;
    tick();
    checks++;
    if (bif.cpu_done !== 1'b0) $display("FAIL rd0_done_pulse: done=%b want 0", bif.cpu_done);
    else passes++;
  endtask

  task automatic test_write_wait3();
    logic [AW-1:0] a = 30'h0000_0100;
    logic [DW-1:0] wd = 32'h1234_5678;
    bif.cpu_req = 1'b1; bif.cpu_addr = a; bif.cpu_rw = 1'b0; bif.cpu_wr_data = wd;
    bif.bus_grnt = 1'b1; bif.bus_rdy = 1'b0; bif.bus_rd_data = 32'hFFFF_0000;
    sb.push_back('{err: 1'b0, rd: exp_rd});
    tick();
    bif.cpu_req = 1'b0; bif.cpu_wr_data = 32'h0;
    tick();  // ACCESS
    checks++;
    if ({bif.bus_as, bif.bus_rw, bif.bus_addr, bif.bus_wr_data} !== {2'b10, a, wd})
      $display("FAIL wr_strobe: as/rw=%b addr=%h data=%h", {bif.bus_as, bif.bus_rw},
               bif.bus_addr, bif.bus_wr_data);
    else passes++;
    bif.bus_grnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();  // WAIT cycle i+1
      checks++;
      if ({bif.bus_req, bif.bus_as, bif.cpu_done, bif.bus_rw, bif.bus_addr, bif.bus_wr_data}
          !== {4'b1000, a, wd})
        $display("FAIL wr_wait%0d: req/as/done/rw=%b addr=%h data=%h", i,
                 {bif.bus_req, bif.bus_as, bif.cpu_done, bif.bus_rw}, bif.bus_addr, bif.bus_wr_data);
      else passes++;
    end
    bif.bus_rdy = 1'b1;
    tick();
    checks++;
    if ({bif.cpu_done, bif.bus_req, bif.cpu_rd_data} !== {2'b10, exp_rd})
      $display("FAIL wr_done: done/req=%b rd=%h want 10 rd=%h",
               {bif.cpu_done, bif.bus_req}, bif.cpu_rd_data, exp_rd);
    else passes++;
    bif.bus_rdy = 1'b0;
    tick();
  endtask

  task automatic test_grant_delay();
    bif.cpu_req = 1'b1; bif.cpu_addr = 30'h0000_2000; bif.cpu_rw = 1'b1;
    bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b1; bif.bus_rd_data = 32'hA5A5_0001;
    exp_rd = 32'hA5A5_0001;
    sb.push_back('{err: 1'b0, rd: 32'hA5A5_0001});
    tick();
    bif.cpu_req = 1'b0;
    // longer than TIMEOUT: arbitration must not trip the watchdog
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bif.bus_req, bif.bus_as, bif.cpu_err} !== 3'b100)
        $display("FAIL gnt_wait%0d: req/as/err=%b want 100", i, {bif.bus_req, bif.bus_as, bif.cpu_err});
      else passes++;
    end
    bif.bus_grnt = 1'b1;
    tick();
    checks++;
    if (bif.bus_as !== 1'b1) $display("FAIL gnt_strobe: as=%b want 1", bif.bus_as);
    else passes++;
    tick();
    checks++;
    if (bif.cpu_done !== 1'b1) $display("FAIL gnt_done: done=%b want 1", bif.cpu_done);
    else passes++;
    bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b0;
    tick();
  endtask

  // rdy_last=1 raises ready in the final cycle before the abort threshold.
  task automatic test_timeout(input logic rdy_last, input logic [DW-1:0] d);
    bif.cpu_req = 1'b1; bif.cpu_addr = 30'h0000_3000; bif.cpu_rw = 1'b1;
    bif.bus_grnt = 1'b1; bif.bus_rdy = 1'b0; bif.bus_rd_data = d;
    if (rdy_last) exp_rd = d;
    sb.push_back('{err: !rdy_last, rd: exp_rd});
    tick();
    bif.cpu_req = 1'b0;
    tick();  // ACCESS, watchdog cycle 1
    bif.bus_grnt = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();  // cycles 2..TO
      checks++;
      if ({bif.bus_req, bif.cpu_busy, bif.cpu_err, bif.cpu_done} !== 4'b1100)
        $display("FAIL to_wait%0d: req/busy/err/done=%b want 1100", i,
                 {bif.bus_req, bif.cpu_busy, bif.cpu_err, bif.cpu_done});
      else passes++;
    end
    bif.bus_rdy = rdy_last;
    tick();
    checks++;
    if ({bif.bus_req, bif.bus_as, bif.cpu_busy, bif.cpu_err, bif.cpu_done, bif.cpu_rd_data}
        !== {3'b000, !rdy_last, rdy_last, exp_rd})
      $display("FAIL to_end: req/as/busy/err/done=%b rd=%h want %b rd=%h",
               {bif.bus_req, bif.bus_as, bif.cpu_busy, bif.cpu_err, bif.cpu_done},
               bif.cpu_rd_data, {3'b000, !rdy_last, rdy_last}, exp_rd);
    else passes++;
    bif.bus_rdy = 1'b0;
    tick();
    checks++;
    if ({bif.cpu_err, bif.cpu_done} !== 2'b00)
      $display("FAIL to_pulse: err/done=%b want 00", {bif.cpu_err, bif.cpu_done});
    else passes++;
  endtask

  task automatic test_reset_mid();
    bif.cpu_req = 1'b1; bif.cpu_addr = 30'h0000_0555; bif.cpu_rw = 1'b0;
    bif.cpu_wr_data = 32'hCAFE_0001; bif.bus_grnt = 1'b1; bif.bus_rdy = 1'b0;
    tick();
    bif.cpu_req = 1'b0;
    tick();  // ACCESS
    tick();  // WAIT
    rest = 1'b1;
    bif.bus_rdy = 1'b1;  // ready during reset must not complete anything
    tick();
    exp_rd = '0;
    checks++;
    if ({bif.bus_req, bif.bus_as, bif.bus_addr, bif.bus_rw, bif.bus_wr_data,
         bif.cpu_busy, bif.cpu_done, bif.cpu_err, bif.cpu_rd_data} !== RST_VALS)
      $display("FAIL mid_reset: got %h want %h",
               {bif.bus_req, bif.bus_as, bif.bus_addr, bif.bus_rw, bif.bus_wr_data,
                bif.cpu_busy, bif.cpu_done, bif.cpu_err, bif.cpu_rd_data}, RST_VALS);
    else passes++;
    rest = 1'b0;
    bif.bus_rdy = 1'b0; bif.bus_grnt = 1'b0;
    tick();
    checks++;
    if ({bif.bus_req, bif.cpu_busy, bif.cpu_done, bif.cpu_err} !== 4'b0000)
      $display("FAIL post_reset: req/busy/done/err=%b want 0000",
               {bif.bus_req, bif.cpu_busy, bif.cpu_done, bif.cpu_err});
    else passes++;
  endtask

  task automatic test_back_to_back();
    bif.cpu_req = 1'b1; bif.cpu_addr = 30'h0000_4000; bif.cpu_rw = 1'b1;
    bif.bus_grnt = 1'b1; bif.bus_rdy = 1'b1; bif.bus_rd_data = 32'h1111_1111;
    sb.push_back('{err: 1'b0, rd: 32'h1111_1111});
    sb.push_back('{err: 1'b0, rd: 32'h2222_2222});
    tick();
    checks++;
    if ({bif.bus_req, bif.bus_addr} !== {1'b1, 30'h0000_4000})
      $display("FAIL b2b_req1: req=%b addr=%h", bif.bus_req, bif.bus_addr);
    else passes++;
    bif.cpu_addr = 30'h0000_4004;  // must be ignored while busy
    tick();
    checks++;
    if ({bif.bus_as, bif.bus_addr} !== {1'b1, 30'h0000_4000})
      $display("FAIL b2b_busy_ignore: as=%b addr=%h want 1 4000", bif.bus_as, bif.bus_addr);
    else passes++;
    tick();
    checks++;
    if ({bif.cpu_done, bif.bus_req} !== 2'b10)
      $display("FAIL b2b_idle_gap: done/req=%b want 10", {bif.cpu_done, bif.bus_req});
    else passes++;
    bif.bus_rd_data = 32'h2222_2222;
    tick();
    checks++;
    if ({bif.bus_req, bif.bus_addr} !== {1'b1, 30'h0000_4004})
      $display("FAIL b2b_req2: req=%b addr=%h want 1 4004", bif.bus_req, bif.bus_addr);
    else passes++;
    bif.cpu_req = 1'b0;
    tick();
    tick();
    exp_rd = 32'h2222_2222;
    checks++;
    if ({bif.cpu_done, bif.bus_req} !== 2'b10)
      $display("FAIL b2b_done2: done/req=%b want 10", {bif.cpu_done, bif.bus_req});
    else passes++;
    bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait(30'h1000_0004, 32'hDEAD_BEEF);
    test_write_wait3();
    test_grant_delay();
    test_timeout(1'b0, 32'hBAD0_BAD0);
    test_read_zero_wait(30'h0000_0040, 32'h600D_0001);
    test_timeout(1'b1, 32'hC0FF_EE11);
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d outstanding, want 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
